// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter with multi-cycle grant ownership and grant lock.
// A requester that wins keeps the resource for up to weight+1 cycles. It keeps it
// indefinitely while lock is high. The grant, owner index and valid are all registered.
module wrr_arbiter #(
    parameter int N  = 4,
    parameter int WW = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          req,
    input  logic [N*WW-1:0]       weight,
    input  logic                  lock,
    output logic [N-1:0]          gnt,
    output logic [$clog2(N)-1:0]  gnt_id,
    output logic                  valid
);

    localparam int IW = $clog2(N);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [WW-1:0]   credit_q, credit_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [IW-1:0]   gnt_id_q, gnt_id_d;
    logic            valid_q, valid_d;

    logic            start_grant;
    logic [IW-1:0]   search_from;
    logic [IW-1:0]   winner;

    // Successor index with explicit wrap, so non-power-of-two N never reaches index N.
    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] k);
        return (k == IW'(N - 1)) ? '0 : k + IW'(1);
    endfunction

    // First requester at or after start, walking all N positions with wrap.
    function automatic logic [IW-1:0] arb(input logic [N-1:0] r, input logic [IW-1:0] start);
        logic [IW-1:0] idx;
        logic          found;
        arb   = start;
        idx   = start;
        found = 1'b0;
        for (int o = 0; o < N; o++) begin
            if (!found && r[idx]) begin
                arb   = idx;
                found = 1'b1;
            end
            idx = next_idx(idx);
        end
    endfunction

    // Burst credit of requester k, sampled only at the moment its grant starts.
    function automatic logic [WW-1:0] weight_of(input logic [N*WW-1:0] w, input logic [IW-1:0] k);
        return w[int'(k)*WW +: WW];
    endfunction

    // Next-state decision: release beats lock, lock beats credit, empty credit rotates.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        credit_d    = credit_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        valid_d     = valid_q;
        start_grant = 1'b0;
        search_from = ptr_q;
        winner      = '0;

        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    start_grant = 1'b1;
                    search_from = ptr_q;
                end
            end
            GRANT: begin
                if (!req[gnt_id_q]) begin
                    ptr_d = next_idx(gnt_id_q);
                    if (|req) begin
                        start_grant = 1'b1;
                        search_from = next_idx(gnt_id_q);
                    end else begin
                        state_d  = IDLE;
                        gnt_d    = '0;
                        gnt_id_d = '0;
                        valid_d  = 1'b0;
                        credit_d = '0;
                    end
                end else if (lock) begin
                    credit_d = credit_q;
                end else if (credit_q != '0) begin
                    credit_d = credit_q - WW'(1);
                end else begin
                    ptr_d       = next_idx(gnt_id_q);
                    start_grant = 1'b1;
                    search_from = next_idx(gnt_id_q);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (start_grant) begin
            winner   = arb(req, search_from);
            state_d  = GRANT;
            gnt_d    = N'(1) << winner;
            gnt_id_d = winner;
            valid_d  = 1'b1;
            credit_d = weight_of(weight, winner);
        end
    end

    // State and registered outputs, cleared synchronously by rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            credit_q <= '0;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            valid_q  <= valid_d;
        end
    end

    assign gnt    = gnt_q;
    assign gnt_id = gnt_id_q;
    assign valid  = valid_q;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Bench for wrr_arbiter: a 4-way and a 3-way instance checked against a turn-based
// reference model (owner, pointer, cycles spent in the current turn).
module tb_wrr_arbiter;

    logic        clk;
    logic        rst;

    logic [3:0]  req4;
    logic [15:0] weight4;
    logic        lock4;
    logic [3:0]  gnt4;
    logic [1:0]  gnt_id4;
    logic        valid4;

    logic [2:0]  req3;
    logic [11:0] weight3;
    logic        lock3;
    logic [2:0]  gnt3;
    logic [1:0]  gnt_id3;
    logic        valid3;

    int tests_run;
    int tests_failed;

    wrr_arbiter #(.N(4), .WW(4)) dut (
        .clk(clk), .rst(rst), .req(req4), .weight(weight4), .lock(lock4),
        .gnt(gnt4), .gnt_id(gnt_id4), .valid(valid4)
    );

    wrr_arbiter #(.N(3), .WW(4)) dut3 (
        .clk(clk), .rst(rst), .req(req3), .weight(weight3), .lock(lock3),
        .gnt(gnt3), .gnt_id(gnt_id3), .valid(valid3)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // A turn: who owns the resource, how many unlocked hold cycles it has used,
    // and how many it is allowed before the turn passes on.
    typedef struct {
        int owner;
        int ptr;
        int spent;
        int wt;
    } model_t;

    model_t m4;
    model_t m3;

    function automatic int search(logic [31:0] r, int n, int start);
        for (int o = 0; o < n; o++) begin
            if (r[(start + o) % n]) return (start + o) % n;
        end
        return -1;
    endfunction

    function automatic model_t model_reset();
        model_t m;
        m.owner = -1;
        m.ptr   = 0;
        m.spent = 0;
        m.wt    = 0;
        return m;
    endfunction

    function automatic model_t new_turn(model_t m, logic [31:0] r, int n, int start, logic [15:0] w);
        m.owner = search(r, n, start);
        m.spent = 0;
        m.wt    = (m.owner >= 0) ? int'(w[m.owner*4 +: 4]) : 0;
        return m;
    endfunction

    function automatic model_t model_step(model_t m, int n, logic [31:0] r, logic lk,
                                          logic [15:0] w, logic rs);
        int k;
        r = r & ((32'd1 << n) - 32'd1);
        if (rs) return model_reset();
        if (m.owner < 0) begin
            if (r != 0) m = new_turn(m, r, n, m.ptr, w);
            return m;
        end
        k = m.owner;
        if (!r[k]) begin
            m.ptr = (k + 1) % n;
            if (r != 0) m = new_turn(m, r, n, m.ptr, w);
            else        m.owner = -1;
        end else if (lk) begin
            m.spent = m.spent;
        end else if (m.spent < m.wt) begin
            m.spent++;
        end else begin
            m.ptr = (k + 1) % n;
            m = new_turn(m, r, n, m.ptr, w);
        end
        return m;
    endfunction

    function automatic int exp_gnt(model_t m);
        return (m.owner < 0) ? 0 : (1 << m.owner);
    endfunction

    function automatic int exp_id(model_t m);
        return (m.owner < 0) ? 0 : m.owner;
    endfunction

    // One clock: advance both models with the inputs seen at the edge, settle #1 after.
    task automatic tick();
        @(posedge clk);
        m4 = model_step(m4, 4, 32'(req4), lock4, weight4, rst);
        m3 = model_step(m3, 3, 32'(req3), lock3, {4'd0, weight3}, rst);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req4 = '0; lock4 = 1'b0; weight4 = '0;
        req3 = '0; lock3 = 1'b0; weight3 = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (gnt4 !== 4'b0000) begin
            tests_failed++; $display("[TB] FAIL reset gnt: got %b want 0000", gnt4);
        end
        tests_run++;
        if (valid4 !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL reset valid: got %b want 0", valid4);
        end
        tests_run++;
        if (gnt_id4 !== 2'd0) begin
            tests_failed++; $display("[TB] FAIL reset gnt_id: got %0d want 0", gnt_id4);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] seq [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                4'b0001, 4'b0010, 4'b0100, 4'b1000};
        do_reset();
        req4 = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            tick();
            tests_run++;
            if (gnt4 !== seq[c]) begin
                tests_failed++;
                $display("[TB] FAIL round_robin gnt cycle %0d: got %b want %b", c, gnt4, seq[c]);
            end
            tests_run++;
            if ({30'd0, gnt_id4} !== 32'(exp_id(m4)) || valid4 !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL round_robin id/valid cycle %0d: got %0d/%b want %0d/1",
                         c, gnt_id4, valid4, exp_id(m4));
            end
        end
    endtask

    task automatic test_weighted();
        logic [3:0] seq [10] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0100,
                                 4'b0100, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
        do_reset();
        weight4 = {4'd0, 4'd1, 4'd0, 4'd3};
        req4    = 4'b0101;
        for (int c = 0; c < 10; c++) begin
            tick();
            tests_run++;
            if (gnt4 !== seq[c]) begin
                tests_failed++;
                $display("[TB] FAIL weighted gnt cycle %0d: got %b want %b", c, gnt4, seq[c]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] seq [3] = '{4'b0010, 4'b0010, 4'b1000};
        do_reset();
        weight4 = {4'd0, 4'd0, 4'd5, 4'd0};
        req4    = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            tick();
            req4 = (c == 0) ? 4'b1010 : 4'b1000;
            tests_run++;
            if (gnt4 !== seq[c] || valid4 !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL back_to_back cycle %0d: got %b/%b want %b/1",
                         c, gnt4, valid4, seq[c]);
            end
        end
    endtask

    task automatic test_lock();
        do_reset();
        req4 = 4'b0100;
        tick();
        req4  = 4'b1111;
        lock4 = 1'b1;
        for (int c = 1; c < 6; c++) begin
            tests_run++;
            if (gnt4 !== 4'b0100) begin
                tests_failed++;
                $display("[TB] FAIL lock hold cycle %0d: got %b want 0100", c, gnt4);
            end
            tick();
        end
        tests_run++;
        if (gnt4 !== 4'b0100) begin
            tests_failed++; $display("[TB] FAIL lock hold cycle 6: got %b want 0100", gnt4);
        end
        lock4 = 1'b0;
        tick();
        tests_run++;
        if (gnt4 !== 4'b1000 || gnt_id4 !== 2'd3) begin
            tests_failed++;
            $display("[TB] FAIL lock release: got %b id %0d want 1000 id 3", gnt4, gnt_id4);
        end
    endtask

    task automatic test_wrap_n3();
        logic [2:0] seq [3] = '{3'b001, 3'b100, 3'b001};
        do_reset();
        req3 = 3'b101;
        for (int c = 0; c < 3; c++) begin
            tick();
            tests_run++;
            if (gnt3 !== seq[c]) begin
                tests_failed++;
                $display("[TB] FAIL wrap_n3 gnt cycle %0d: got %b want %b", c, gnt3, seq[c]);
            end
        end
        req3 = 3'b000;
        tick();
        tests_run++;
        if (valid3 !== 1'b0 || gnt_id3 !== 2'd0 || gnt3 !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL wrap_n3 idle: got %b/%0d/%b want 0/0/000", valid3, gnt_id3, gnt3);
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        weight4 = {4'd0, 4'd0, 4'd0, 4'd2};
        req4    = 4'b0001;
        tick();
        tests_run++;
        if (gnt4 !== 4'b0001) begin
            tests_failed++; $display("[TB] FAIL mid_reset setup: got %b want 0001", gnt4);
        end
        rst = 1'b1;
        tick();
        tests_run++;
        if (gnt4 !== 4'b0000 || valid4 !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset drop: got %b/%b want 0000/0", gnt4, valid4);
        end
        rst  = 1'b0;
        req4 = 4'b1000;
        tick();
        tests_run++;
        if (gnt4 !== 4'b1000 || gnt_id4 !== 2'd3) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset regrant: got %b id %0d want 1000 id 3", gnt4, gnt_id4);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            req4  = 4'($urandom_range(0, 15));
            lock4 = ($urandom_range(0, 7) == 0);
            req3  = 3'($urandom_range(0, 7));
            lock3 = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 9) == 0) weight4 = 16'($urandom) & 16'h3333;
            if ($urandom_range(0, 9) == 0) weight3 = 12'($urandom) & 12'h333;
            rst = ($urandom_range(0, 59) == 0);
            tick();
            tests_run++;
            if ({28'd0, gnt4} !== 32'(exp_gnt(m4)) || valid4 !== (m4.owner >= 0) ||
                {30'd0, gnt_id4} !== 32'(exp_id(m4))) begin
                tests_failed++;
                $display("[TB] FAIL random n4 cycle %0d: got %b/%0d/%b want %b/%0d/%b", c,
                         gnt4, gnt_id4, valid4, 4'(exp_gnt(m4)), exp_id(m4), m4.owner >= 0);
            end
            tests_run++;
            if ({29'd0, gnt3} !== 32'(exp_gnt(m3)) || valid3 !== (m3.owner >= 0) ||
                {30'd0, gnt_id3} !== 32'(exp_id(m3))) begin
                tests_failed++;
                $display("[TB] FAIL random n3 cycle %0d: got %b/%0d/%b want %b/%0d/%b", c,
                         gnt3, gnt_id3, valid3, 3'(exp_gnt(m3)), exp_id(m3), m3.owner >= 0);
            end
        end
        rst = 1'b0;
    endtask

    // Scenario sequence followed by the summary.
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        m4 = model_reset();
        m3 = model_reset();
        rst = 1'b1;
        req4 = '0; lock4 = 1'b0; weight4 = '0;
        req3 = '0; lock3 = 1'b0; weight3 = '0;
        test_reset();
        test_round_robin();
        test_weighted();
        test_back_to_back();
        test_lock();
        test_wrap_n3();
        test_reset_mid_grant();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
